// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: UART byte stream to CAN frame assembler with inter-byte timeout; define UART_FRAME_CHECKSUM_EN for the trailing XOR checksum byte
module uart_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  uart_rx_data_bus,
    input  logic        uart_data_ready,
    output logic        R_byte,
    output logic [10:0] can_id,
    output logic [3:0]  can_dlc,
    output logic [63:0] can_data,
    output logic        frame_valid,
    input  logic        frame_ack,
    output logic        frame_err,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE, ID_H, ID_L, LEN, DATA,
`ifdef UART_FRAME_CHECKSUM_EN
        CSUM,
`endif
        HOLD
    } state_t;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam state_t TAIL = CSUM;
`else
    localparam state_t TAIL = HOLD;
`endif
    localparam logic [15:0] TMO_MAX = 16'(TIMEOUT_CYCLES - 1);
    state_t      state, nxt;
    logic [15:0] tmo;
    logic [3:0]  cnt;
    logic        err_nxt;
    logic        timed;
    logic        expire;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]  csum;
`endif
    assign busy        = state != IDLE;
    assign frame_valid = state == HOLD;
    assign R_byte      = !frame_valid;
    assign timed       = busy && !frame_valid;
    assign expire      = timed && !uart_data_ready && tmo == TMO_MAX;
    always_comb begin
        nxt     = state;
        err_nxt = 1'b0;
        if (expire) begin
            nxt     = IDLE;
            err_nxt = 1'b1;
        end else if (uart_data_ready) begin
            case (state)
                IDLE: nxt = (uart_rx_data_bus == SYNC_BYTE) ? ID_H : IDLE;
                ID_H: begin
                    err_nxt = |uart_rx_data_bus[7:3];
                    nxt     = err_nxt ? IDLE : ID_L;
                end
                ID_L: nxt = LEN;
                LEN: begin
                    err_nxt = uart_rx_data_bus > 8'd8;
                    nxt     = err_nxt ? IDLE : (uart_rx_data_bus == 8'd0) ? TAIL : DATA;
                end
                DATA: nxt = (cnt == can_dlc - 4'd1) ? TAIL : DATA;
`ifdef UART_FRAME_CHECKSUM_EN
                CSUM: begin
                    err_nxt = uart_rx_data_bus != csum;
                    nxt     = err_nxt ? IDLE : HOLD;
                end
`endif
                HOLD: err_nxt = 1'b1;
                default: nxt = IDLE;
            endcase
        end
        if (frame_valid && frame_ack)
            nxt = IDLE;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            can_id    <= '0;
            can_dlc   <= '0;
            can_data  <= '0;
            frame_err <= 1'b0;
            tmo       <= '0;
            cnt       <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= nxt;
            frame_err <= err_nxt;
            tmo       <= (uart_data_ready || !timed || expire) ? '0 : tmo + 16'd1;
            if (uart_data_ready) begin
                case (state)
                    IDLE: if (uart_rx_data_bus == SYNC_BYTE) begin
                        can_data <= '0;
                        cnt      <= '0;
                    end
                    ID_H: if (nxt == ID_L) can_id[10:8] <= uart_rx_data_bus[2:0];
                    ID_L: can_id[7:0] <= uart_rx_data_bus;
                    LEN:  if (!err_nxt) can_dlc <= uart_rx_data_bus[3:0];
                    DATA: begin
                        can_data[{cnt[2:0], 3'b000} +: 8] <= uart_rx_data_bus;
                        cnt <= cnt + 4'd1;
                    end
                    default: ;
                endcase
`ifdef UART_FRAME_CHECKSUM_EN
                csum <= (state == IDLE) ? 8'd0 : csum ^ uart_rx_data_bus;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed frames checked every cycle against a byte-queue frame model
module tb_uart_frame_ctrl;
    localparam int T = 20;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b0, ack = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        R_byte, frame_valid, frame_err, busy;
    logic [10:0] can_id;
    logic [3:0]  can_dlc;
    logic [63:0] can_data;
    int total = 0, bad = 0;

    uart_frame_ctrl #(.SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(T)) dut (
        .clock(clk), .reset(rst_n), .uart_rx_data_bus(din), .uart_data_ready(rdy),
        .R_byte(R_byte), .can_id(can_id), .can_dlc(can_dlc), .can_data(can_data),
        .frame_valid(frame_valid), .frame_ack(ack), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: bytes of the frame in progress are queued; the frame is judged on its contents
    logic [7:0]  q[$];
    bit          hold = 0, exp_err = 0, fresh = 1, ok;
    int          quiet = 0, n;
    logic [7:0]  x;
    logic [10:0] exp_id = 0;
    logic [3:0]  exp_dlc = 0;
    logic [63:0] exp_data = 0;

    always @(posedge clk) begin
        exp_err = 0;
        if (!rst_n) begin
            q.delete(); hold = 0; quiet = 0; fresh = 1;
            exp_id = 0; exp_dlc = 0; exp_data = 0;
        end else if (hold) begin
            if (rdy) exp_err = 1;
            if (ack) hold = 0;
        end else if (rdy) begin
            quiet = 0;
            if (q.size() == 0) begin
                if (din == 8'hAA) begin q.push_back(din); fresh = 0; end
            end else begin
                q.push_back(din);
                n = q.size();
                if ((n == 2 && q[1][7:3] != 0) || (n == 4 && q[3] > 8)) begin
                    exp_err = 1; q.delete();
                end else if (n >= 4 && n == 4 + int'(q[3]) + CS) begin
                    x = 0;
                    for (int i = 1; i < n - CS; i++) x = x ^ q[i];
                    ok = (CS == 0) || (x == q[n-1]);
                    if (ok) begin
                        hold = 1;
                        exp_id = {q[1][2:0], q[2]};
                        exp_dlc = q[3][3:0];
                        exp_data = 0;
                        for (int i = 0; i < int'(q[3]); i++) exp_data[8*i +: 8] = q[4+i];
                    end else exp_err = 1;
                    q.delete();
                end
            end
        end else if (q.size() != 0) begin
            quiet++;
            if (quiet == T) begin exp_err = 1; q.delete(); end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_loop();
        forever begin
            @(negedge clk);
            chk("frame_valid", frame_valid, hold);
            chk("busy", busy, q.size() != 0 || hold);
            chk("R_byte", R_byte, !hold);
            chk("frame_err", frame_err, exp_err);
            if (hold || fresh) begin
                chk("can_id", can_id, exp_id);
                chk("can_dlc", can_dlc, exp_dlc);
                chk("can_data", can_data, exp_data);
            end
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        din = b; rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_rbyte", R_byte, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_id", can_id, 11'h0);
        chk("rst_data", can_data, 64'h0);
        rst_n = 1'b1;
        fork check_loop(); join_none
        tick(1);
        pulse_ack();
        chk("ack_idle_busy", busy, 1'b0);
        send(8'hAA); send(8'h01); send(8'h23); send(8'h02); send(8'h55);
        chk("f1_not_yet", frame_valid, 1'b0);
        send(8'h66);
`ifdef UART_FRAME_CHECKSUM_EN
        chk("f1_csum_wait", frame_valid, 1'b0);
        send(8'h13);
`endif
        chk("f1_valid", frame_valid, 1'b1);
        chk("f1_id", can_id, 11'h123);
        chk("f1_dlc", can_dlc, 4'd2);
        chk("f1_data", can_data, 64'h6655);
        chk("f1_rbyte", R_byte, 1'b0);
        send(8'h77);
        chk("hold_inj_err", frame_err, 1'b1);
        chk("hold_inj_data", can_data, 64'h6655);
        chk("hold_inj_valid", frame_valid, 1'b1);
        tick(3);
        chk("hold_stays", frame_valid, 1'b1);
        pulse_ack();
        chk("ack_valid", frame_valid, 1'b0);
        chk("ack_rbyte", R_byte, 1'b1);
        tick(1);
        send(8'h13); send(8'hAA); send(8'h07); send(8'hFF); send(8'h00);
`ifdef UART_FRAME_CHECKSUM_EN
        send(8'hF8);
`endif
        chk("f2_valid", frame_valid, 1'b1);
        chk("f2_id", can_id, 11'h7FF);
        chk("f2_dlc", can_dlc, 4'd0);
        chk("f2_data", can_data, 64'h0);
        pulse_ack();
        chk("f2_ack_rbyte", R_byte, 1'b1);
        send(8'hAA); send(8'h08);
        chk("bad_idh_err", frame_err, 1'b1);
        chk("bad_idh_busy", busy, 1'b0);
        send(8'hAA); send(8'h00); send(8'h10); send(8'h09);
        chk("bad_len_err", frame_err, 1'b1);
        chk("bad_len_busy", busy, 1'b0);
        tick(2);
        send(8'hAA); send(8'h01);
        tick(T);
        chk("tmo_err", frame_err, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        send(8'hAA); send(8'h01);
        tick(T - 1);
        send(8'h23);
        chk("tmo_edge_err", frame_err, 1'b0);
        chk("tmo_edge_busy", busy, 1'b1);
        send(8'h02); send(8'h55); send(8'h66);
`ifdef UART_FRAME_CHECKSUM_EN
        send(8'h13);
`endif
        chk("tmo_edge_valid", frame_valid, 1'b1);
        chk("tmo_edge_data", can_data, 64'h6655);
        pulse_ack();
`ifdef UART_FRAME_CHECKSUM_EN
        send(8'hAA); send(8'h01); send(8'h23); send(8'h02); send(8'h55); send(8'h66); send(8'h00);
        chk("bad_csum_err", frame_err, 1'b1);
        chk("bad_csum_valid", frame_valid, 1'b0);
`endif
        send(8'hAA); send(8'h02); send(8'h34); send(8'h03); send(8'h11); send(8'h22);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_err", frame_err, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_id", can_id, 11'h0);
        chk("mid_rst_data", can_data, 64'h0);
        chk("mid_rst_rbyte", R_byte, 1'b1);
        rst_n = 1'b1;
        tick(2);
        send(8'hAA); send(8'h05); send(8'hA5); send(8'h08);
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
`ifdef UART_FRAME_CHECKSUM_EN
        send(8'h05 ^ 8'hA5 ^ 8'h08);
`endif
        chk("f8_id", can_id, 11'h5A5);
        chk("f8_data", can_data, 64'h1716151413121110);
        pulse_ack();
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
